// File: rtl/coherence_pkg.sv
// Types and helpers for the N-core snooping bus controller.
package coherence_pkg;

  typedef enum logic [2:0] {
    IDLE,
    IFETCH,
    WRITE,
    SNOOP,
    C2C_X,
    C2C_FLUSH,
    RAMRD
  } bus_state_t;

  function automatic int unsigned word_cnt_width(input int unsigned wpb);
    return $clog2(wpb + 1);
  endfunction

  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types used across the cache and bus blocks.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/coherence_bus_ctrl_rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 valid
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned JW = IW + 1;

  logic [JW-1:0] jw;
  logic [IW-1:0] j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    jw    = '0;
    j     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      // One spare bit so the wrap works for non-power-of-two N.
      jw = {1'b0, ptr} + JW'(i);
      if (jw >= JW'(N)) jw = jw - JW'(N);
      j = jw[IW-1:0];
      if (!valid && req[j]) begin
        valid  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// N-core bus controller: round-robin arbitration, snoop broadcast, supplier
// selection, block transfers between L1 caches and a single-ported RAM.
module coherence_bus_ctrl
  import cpu_types_pkg::*;
  import coherence_pkg::*;
#(
  parameter int unsigned CPUS            = 2,
  parameter int unsigned WORDS_PER_BLOCK = 2,
  parameter int unsigned SNOOP_CYCLES    = 1
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [CPUS-1:0]      iREN,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  logic [CPUS*32-1:0]   iaddr,
  input  logic [CPUS*32-1:0]   daddr,
  input  logic [CPUS*32-1:0]   dstore,
  input  logic [CPUS-1:0]      ccwrite,
  input  logic [CPUS-1:0]      cctrans,
  output logic [CPUS*32-1:0]   iload,
  output logic [CPUS*32-1:0]   dload,
  output logic [CPUS-1:0]      iwait,
  output logic [CPUS-1:0]      dwait,
  output logic [CPUS-1:0]      ccwait,
  output logic [CPUS-1:0]      ccinv,
  output logic [CPUS*32-1:0]   ccsnoopaddr,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [31:0]          ramaddr,
  output logic [31:0]          ramstore,
  input  logic [31:0]          ramload,
  input  ramstate_t            ramstate
);

  localparam int unsigned PW  = $clog2(CPUS);
  localparam int unsigned PW1 = PW + 1;
  localparam int unsigned CW  = word_cnt_width(WORDS_PER_BLOCK);
  localparam int unsigned SW  = $clog2(SNOOP_CYCLES + 1);

  bus_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [SW-1:0] scnt, scnt_n;
  logic [PW-1:0] dptr, dptr_n, iptr, iptr_n;
  logic [PW-1:0] grant, grant_n, sup, sup_n;
  logic [PW+4:0] goff, soff;

  logic [CPUS-1:0] dgnt, ignt;
  logic [PW-1:0]   didx, iidx;
  logic            dvalid, ivalid;
  logic            acc, last, step, snoop_drive, found;
  logic [PW-1:0]   sk;
  logic [PW1-1:0]  kw;
  logic            unused_ignt;

  rr_arbiter #(.N(CPUS)) u_darb (
    .req   (dREN | dWEN),
    .ptr   (dptr),
    .gnt   (dgnt),
    .idx   (didx),
    .valid (dvalid)
  );

  rr_arbiter #(.N(CPUS)) u_iarb (
    .req   (iREN),
    .ptr   (iptr),
    .gnt   (ignt),
    .idx   (iidx),
    .valid (ivalid)
  );

  assign unused_ignt = ^ignt;
  assign goff = {grant, 5'b0};
  assign soff = {sup, 5'b0};
  assign acc  = (ramstate == ACCESS);
  assign last = (cnt == CW'(WORDS_PER_BLOCK - 1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      cnt   <= '0;
      scnt  <= '0;
      dptr  <= '0;
      iptr  <= '0;
      grant <= '0;
      sup   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      scnt  <= scnt_n;
      dptr  <= dptr_n;
      iptr  <= iptr_n;
      grant <= grant_n;
      sup   <= sup_n;
    end
  end

  always_comb begin
    iwait       = '1;
    dwait       = '1;
    ccwait      = '0;
    ccinv       = '0;
    iload       = '0;
    dload       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    state_n     = state;
    cnt_n       = cnt;
    scnt_n      = scnt;
    dptr_n      = dptr;
    iptr_n      = iptr;
    grant_n     = grant;
    sup_n       = sup;
    step        = 1'b0;
    snoop_drive = 1'b0;
    found       = 1'b0;
    sk          = '0;
    kw          = '0;

    // A granted core dropping its request aborts with all outputs at default.
    case (state)
      IDLE: begin
        cnt_n  = '0;
        scnt_n = '0;
        if (dvalid) begin
          grant_n = didx;
          dptr_n  = PW'(wrap_inc(32'(didx), CPUS));
          state_n = (|(dgnt & dWEN)) ? WRITE : SNOOP;
        end else if (ivalid) begin
          grant_n = iidx;
          iptr_n  = PW'(wrap_inc(32'(iidx), CPUS));
          state_n = IFETCH;
        end
      end

      IFETCH: begin
        if (!iREN[grant]) begin
          state_n = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr[goff +: 32];
          if (acc) begin
            iload[goff +: 32] = ramload;
            iwait[grant]      = 1'b0;
            state_n           = IDLE;
          end
        end
      end

      WRITE: begin
        if (!dWEN[grant]) begin
          state_n = IDLE;
        end else begin
          ramWEN   = 1'b1;
          ramaddr  = daddr[goff +: 32];
          ramstore = dstore[goff +: 32];
          if (acc) begin
            dwait[grant] = 1'b0;
            step         = 1'b1;
          end
        end
      end

      SNOOP: begin
        if (!dREN[grant]) begin
          state_n = IDLE;
        end else begin
          snoop_drive = 1'b1;
          if (scnt == SW'(SNOOP_CYCLES - 1)) begin
            scnt_n = '0;
            for (int unsigned i = 1; i < CPUS; i++) begin
              kw = {1'b0, grant} + PW1'(i);
              if (kw >= PW1'(CPUS)) kw = kw - PW1'(CPUS);
              if (!found && cctrans[kw[PW-1:0]]) begin
                found = 1'b1;
                sk    = kw[PW-1:0];
              end
            end
            if (!found) begin
              state_n = RAMRD;
            end else begin
              sup_n   = sk;
              state_n = ccwrite[grant] ? C2C_X : C2C_FLUSH;
            end
          end else begin
            scnt_n = scnt + SW'(1);
          end
        end
      end

      C2C_X: begin
        if (!dREN[grant]) begin
          state_n = IDLE;
        end else begin
          snoop_drive       = 1'b1;
          dload[goff +: 32] = dstore[soff +: 32];
          dwait[grant]      = 1'b0;
          dwait[sup]        = 1'b0;
          step              = 1'b1;
        end
      end

      C2C_FLUSH: begin
        if (!dREN[grant]) begin
          state_n = IDLE;
        end else begin
          snoop_drive       = 1'b1;
          dload[goff +: 32] = dstore[soff +: 32];
          ramWEN            = 1'b1;
          ramaddr           = daddr[soff +: 32];
          ramstore          = dstore[soff +: 32];
          if (acc) begin
            dwait[grant] = 1'b0;
            dwait[sup]   = 1'b0;
            step         = 1'b1;
          end
        end
      end

      RAMRD: begin
        if (!dREN[grant]) begin
          state_n = IDLE;
        end else begin
          ramREN            = 1'b1;
          ramaddr           = daddr[goff +: 32];
          dload[goff +: 32] = ramload;
          if (acc) begin
            dwait[grant] = 1'b0;
            step         = 1'b1;
          end
        end
      end

      default: state_n = IDLE;
    endcase

    if (step) begin
      if (last) begin
        state_n = IDLE;
        cnt_n   = '0;
      end else begin
        cnt_n = cnt + CW'(1);
      end
    end

    if (snoop_drive) begin
      for (int unsigned k = 0; k < CPUS; k++) begin
        if (PW'(k) != grant) begin
          ccwait[PW'(k)]                     = 1'b1;
          ccinv[PW'(k)]                      = ccwrite[grant];
          ccsnoopaddr[{PW'(k), 5'b0} +: 32] = daddr[goff +: 32];
        end
      end
    end
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Bench for coherence_bus_ctrl (4 cores, 2-word blocks): scripted bus
// transactions with random data/stalls against a transaction-level model.
module tb_coherence_bus_ctrl;
  import cpu_types_pkg::*;

  localparam int N   = 4;
  localparam int WPB = 2;
  localparam logic [N-1:0] ALL = '1;

  logic            CLK = 1'b0;
  logic            nRST;
  logic [N-1:0]    iREN, dREN, dWEN, ccwrite, cctrans;
  logic [N*32-1:0] iaddr, daddr, dstore;
  logic [N*32-1:0] iload, dload, ccsnoopaddr;
  logic [N-1:0]    iwait, dwait, ccwait, ccinv;
  logic            ramREN, ramWEN;
  logic [31:0]     ramaddr, ramstore, ramload;
  ramstate_t       ramstate;

  int errors = 0;
  int checks = 0;
  int dptr_m = 0;
  int iptr_m = 0;

  coherence_bus_ctrl #(
    .CPUS            (N),
    .WORDS_PER_BLOCK (WPB),
    .SNOOP_CYCLES    (1)
  ) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .iREN        (iREN),
    .dREN        (dREN),
    .dWEN        (dWEN),
    .iaddr       (iaddr),
    .daddr       (daddr),
    .dstore      (dstore),
    .ccwrite     (ccwrite),
    .cctrans     (cctrans),
    .iload       (iload),
    .dload       (dload),
    .iwait       (iwait),
    .dwait       (dwait),
    .ccwait      (ccwait),
    .ccinv       (ccinv),
    .ccsnoopaddr (ccsnoopaddr),
    .ramREN      (ramREN),
    .ramWEN      (ramWEN),
    .ramaddr     (ramaddr),
    .ramstore    (ramstore),
    .ramload     (ramload),
    .ramstate    (ramstate)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [N*32-1:0] v, input int k);
    logic [N*32-1:0] t;
    t = v >> (32 * k);
    return t[31:0];
  endfunction

  function automatic logic [N*32-1:0] put(input logic [N*32-1:0] v, input int k,
                                          input logic [31:0] x);
    logic [N*32-1:0] m, d;
    m = {{(N-1)*32{1'b0}}, 32'hFFFF_FFFF} << (32 * k);
    d = {{(N-1)*32{1'b0}}, x} << (32 * k);
    return (v & ~m) | d;
  endfunction

  function automatic logic [N-1:0] oh(input int k);
    return N'(1) << k;
  endfunction

  function automatic logic bit_of(input logic [N-1:0] v, input int k);
    logic [N-1:0] t;
    t = v >> k;
    return t[0];
  endfunction

  // Model: first requester at or after ptr, modulo N.
  function automatic int pick(input logic [N-1:0] req, input int ptr);
    for (int i = 0; i < N; i++)
      if (bit_of(req, (ptr + i) % N)) return (ptr + i) % N;
    return -1;
  endfunction

  // Model: first other core holding the block, searching upward from g+1.
  function automatic int supplier(input int g, input logic [N-1:0] tr);
    for (int i = 1; i < N; i++)
      if (bit_of(tr, (g + i) % N)) return (g + i) % N;
    return -1;
  endfunction

  function automatic ramstate_t stall_state(input int nb);
    int r;
    if (nb >= 0) return BUSY;
    r = $urandom_range(0, 2);
    return (r == 0) ? FREE : (r == 1) ? BUSY : ERROR;
  endfunction

  task automatic chk_idle(input string tag);
    check({tag, " waits"}, 32'({iwait, dwait}), 32'({ALL, ALL}));
    check({tag, " bus"}, 32'({ccwait, ccinv, ramREN, ramWEN}), 32'h0);
  endtask

  task automatic do_write(input int g, input int nb);
    int nbw;
    #1 chk_idle("wr arb");
    for (int w = 0; w < WPB; w++) begin
      @(negedge CLK);
      daddr  = put(daddr, g, $urandom & 32'hFFFF_FFFC);
      dstore = put(dstore, g, $urandom);
      nbw = (nb < 0) ? $urandom_range(0, 2) : nb;
      for (int b = 0; b < nbw; b++) begin
        ramstate = stall_state(nb);
        #1;
        check("wr stall en", 32'({ramWEN, ramREN}), 32'b10);
        check("wr stall addr", ramaddr, word_of(daddr, g));
        check("wr stall data", ramstore, word_of(dstore, g));
        check("wr stall dwait", 32'(dwait), 32'(ALL));
        @(negedge CLK);
      end
      ramstate = ACCESS;
      #1;
      check("wr acc en", 32'({ramWEN, ramREN}), 32'b10);
      check("wr acc data", ramstore, word_of(dstore, g));
      check("wr acc dwait", 32'(dwait), 32'(ALL & ~oh(g)));
    end
    @(negedge CLK);
    dWEN = dWEN & ~oh(g);
    ramstate = FREE;
    #1 chk_idle("wr done");
  endtask

  task automatic do_ifetch(input int g, input int nb);
    int nbw;
    iaddr = put(iaddr, g, $urandom & 32'hFFFF_FFFC);
    #1 chk_idle("if arb");
    @(negedge CLK);
    nbw = (nb < 0) ? $urandom_range(0, 2) : nb;
    for (int b = 0; b < nbw; b++) begin
      ramstate = stall_state(nb);
      #1;
      check("if stall en", 32'({ramWEN, ramREN}), 32'b01);
      check("if stall addr", ramaddr, word_of(iaddr, g));
      check("if stall iwait", 32'(iwait), 32'(ALL));
      @(negedge CLK);
    end
    ramstate = ACCESS;
    ramload  = $urandom;
    #1;
    check("if acc addr", ramaddr, word_of(iaddr, g));
    check("if acc iload", word_of(iload, g), ramload);
    check("if acc iwait", 32'(iwait), 32'(ALL & ~oh(g)));
    @(negedge CLK);
    iREN = iREN & ~oh(g);
    ramstate = FREE;
    #1 chk_idle("if done");
  endtask

  // Data read from IDLE through snoop and block transfer, ending in IDLE.
  // abort_after >= 0 drops dREN after that word of a RAM read.
  task automatic do_read(input int g, input logic wr, input logic [N-1:0] tr,
                         input int nb, input int abort_after);
    int s, nbw;
    ccwrite  = wr ? (ccwrite | oh(g)) : (ccwrite & ~oh(g));
    cctrans  = tr;
    daddr    = put(daddr, g, $urandom & 32'hFFFF_FFFC);
    ramstate = FREE;
    #1 chk_idle("rd arb");
    @(negedge CLK);
    #1;
    check("snoop ccwait", 32'(ccwait), 32'(ALL & ~oh(g)));
    check("snoop ccinv", 32'(ccinv), wr ? 32'(ALL & ~oh(g)) : 32'h0);
    for (int k = 0; k < N; k++)
      check("snoop addr", word_of(ccsnoopaddr, k), (k == g) ? 32'h0 : word_of(daddr, g));
    check("snoop ram", 32'({ramWEN, ramREN}), 32'h0);
    s = supplier(g, tr);
    for (int w = 0; w < WPB; w++) begin
      @(negedge CLK);
      if (w > 0 && abort_after == w - 1) begin
        dREN = dREN & ~oh(g);
        ramstate = ACCESS;
        #1;
        check("abort ram", 32'({ramWEN, ramREN}), 32'h0);
        check("abort dwait", 32'(dwait), 32'(ALL));
        @(negedge CLK);
        ramstate = FREE;
        #1 chk_idle("abort idle");
        return;
      end
      nbw = (nb < 0) ? $urandom_range(0, 2) : nb;
      if (s < 0) begin
        daddr = put(daddr, g, word_of(daddr, g) + 32'd4);
        for (int b = 0; b < nbw; b++) begin
          ramstate = stall_state(nb);
          #1;
          check("rd stall en", 32'({ramWEN, ramREN}), 32'b01);
          check("rd stall addr", ramaddr, word_of(daddr, g));
          check("rd stall dwait", 32'(dwait), 32'(ALL));
          check("rd ccwait", 32'(ccwait), 32'h0);
          @(negedge CLK);
        end
        ramstate = ACCESS;
        ramload  = $urandom;
        #1;
        check("rd acc dload", word_of(dload, g), ramload);
        check("rd acc dwait", 32'(dwait), 32'(ALL & ~oh(g)));
      end else if (wr) begin
        dstore   = put(dstore, s, $urandom);
        ramstate = ramstate_t'($urandom_range(0, 3));
        #1;
        check("c2cx dload", word_of(dload, g), word_of(dstore, s));
        check("c2cx dwait", 32'(dwait), 32'(ALL & ~oh(g) & ~oh(s)));
        check("c2cx ram", 32'({ramWEN, ramREN}), 32'h0);
        check("c2cx ccinv", 32'(ccinv), 32'(ALL & ~oh(g)));
      end else begin
        dstore = put(dstore, s, $urandom);
        daddr  = put(daddr, s, $urandom & 32'hFFFF_FFFC);
        for (int b = 0; b < nbw; b++) begin
          ramstate = stall_state(nb);
          #1;
          check("fl stall en", 32'({ramWEN, ramREN}), 32'b10);
          check("fl stall addr", ramaddr, word_of(daddr, s));
          check("fl stall data", ramstore, word_of(dstore, s));
          check("fl stall dload", word_of(dload, g), word_of(dstore, s));
          check("fl stall dwait", 32'(dwait), 32'(ALL));
          @(negedge CLK);
        end
        ramstate = ACCESS;
        #1;
        check("fl acc data", ramstore, word_of(dstore, s));
        check("fl acc dwait", 32'(dwait), 32'(ALL & ~oh(g) & ~oh(s)));
        check("fl ccwait", 32'(ccwait), 32'(ALL & ~oh(g)));
      end
    end
    @(negedge CLK);
    dREN = dREN & ~oh(g);
    ramstate = FREE;
    #1 chk_idle("rd done");
  endtask

  // Serve whichever request the model says wins this IDLE cycle.
  task automatic serve(input logic wr, input logic [N-1:0] tr, input int nb);
    logic [N-1:0] dreq;
    int w;
    dreq = dREN | dWEN;
    if (dreq != '0) begin
      w = pick(dreq, dptr_m);
      dptr_m = (w + 1) % N;
      if (bit_of(dWEN, w)) do_write(w, nb);
      else do_read(w, wr, tr, nb, -1);
    end else if (iREN != '0) begin
      w = pick(iREN, iptr_m);
      iptr_m = (w + 1) % N;
      do_ifetch(w, nb);
    end else begin
      #1 chk_idle("quiet");
      @(negedge CLK);
    end
  endtask

  initial begin
    nRST = 1'b0;
    iREN = '0; dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    for (int k = 0; k < N; k++) begin
      iaddr  = put(iaddr, k, 32'h1000 * (k + 1));
      daddr  = put(daddr, k, 32'h8000 + 32'h100 * k);
      dstore = put(dstore, k, $urandom);
    end
    @(negedge CLK);
    @(negedge CLK);
    #1;
    chk_idle("reset");
    check("reset dload", word_of(dload, 2), 32'h0);
    check("reset iload", word_of(iload, 1), 32'h0);
    check("reset snpaddr", word_of(ccsnoopaddr, 3), 32'h0);
    check("reset ramaddr", ramaddr, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;

    // Arbitration from dptr=0: core 1 then core 3.
    dREN = oh(1) | oh(3);
    serve(1'b0, 4'b0000, 0);
    serve(1'b0, 4'b0000, 0);

    // RAM read with two BUSY cycles per word.
    dREN = oh(0);
    serve(1'b0, 4'b0000, 2);

    // BusRdX with two holders: supplier is core 3.
    dREN = oh(2);
    serve(1'b1, 4'b1010, 1);

    // BusRd with a holder: flush through RAM.
    dREN = oh(0);
    serve(1'b0, 4'b0010, 1);

    // Data write beats a simultaneous fetch.
    dWEN = oh(0);
    iREN = oh(2);
    serve(1'b0, 4'b0000, 1);
    serve(1'b0, 4'b0000, 1);

    // Requester abandons a RAM read after word 0.
    dREN = oh(1);
    dptr_m = 2;
    do_read(1, 1'b0, 4'b0000, 1, 0);

    // Reset in the middle of a flush.
    dREN = oh(0);
    ccwrite = '0;
    cctrans = oh(1);
    dstore = put(dstore, 1, 32'hDEAD_BEEF);
    #1 chk_idle("fl arb");
    @(negedge CLK);
    @(negedge CLK);
    ramstate = BUSY;
    #1;
    check("rst fl ramstore", ramstore, 32'hDEAD_BEEF);
    check("rst fl ramaddr", ramaddr, word_of(daddr, 1));
    check("rst fl dload", word_of(dload, 0), 32'hDEAD_BEEF);
    check("rst fl dwait", 32'(dwait), 32'(ALL));
    nRST = 1'b0;
    #1;
    chk_idle("rst async");
    check("rst async store", ramstore, 32'h0);
    check("rst async dload", word_of(dload, 0), 32'h0);
    check("rst async snp", word_of(ccsnoopaddr, 1), 32'h0);
    dREN = '0; cctrans = '0; ramstate = FREE;
    @(negedge CLK);
    nRST = 1'b1;
    dptr_m = 0;
    iptr_m = 0;

    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < N; k++) begin
        if (!bit_of(iREN | dREN | dWEN, k) && $urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 3))
            0:       iREN = iREN | oh(k);
            1:       dREN = dREN | oh(k);
            2:       dWEN = dWEN | oh(k);
            default: begin dREN = dREN | oh(k); dWEN = dWEN | oh(k); end
          endcase
        end
      end
      serve(1'($urandom_range(0, 1)), N'($urandom), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/coherence_bus_ctrl.md
Name: coherence_bus_ctrl

Overview:
- Parametrised bus controller and snooping-coherence arbiter between CPUS private L1 I/D caches and a single-ported RAM.
- Successor to the fixed two-core controller: arbitrates N cores round-robin, broadcasts snoops to all non-requesters and selects one supplier.
- Moves WORDS_PER_BLOCK-word blocks with a word counter and flushes dirty data to RAM during cache-to-cache transfers.

Parameters:
- CPUS, 2, number of cores; legal range 2..8.
- WORDS_PER_BLOCK, 2, words per cache block; legal range 1..8.
- SNOOP_CYCLES, 1, cycles the snoop is held before cctrans is sampled; minimum 1.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- iREN, dREN, dWEN  in  CPUS each  per-core fetch/read/write requests
- iaddr, daddr, dstore  in  CPUS*32  per-core addresses and store data; core k uses bits [32k+31:32k]
- ccwrite  in  CPUS  requester intends to write (BusRdX); invalidates others
- cctrans  in  CPUS  snooped core holds the block and will supply it
- iload, dload  out  CPUS*32  per-core load data
- iwait, dwait  out  CPUS  per-core stall; 0 means word accepted or returned this cycle
- ccwait  out  CPUS  core is being snooped
- ccinv  out  CPUS  invalidate the snooped block
- ccsnoopaddr  out  CPUS*32  snoop address
- ramREN, ramWEN  out  1  RAM enables
- ramaddr, ramstore  out  32  RAM address and write data
- ramload  in  32  RAM read data
- ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR

Behaviour:
- Reset and default outputs (asserted whenever not overridden): all iwait/dwait=1; ccwait, ccinv, loads, snoop addresses, ramREN/WEN, ramaddr, ramstore=0. State IDLE; word counter, dptr, iptr, grant=0.
- IDLE arbitration:
  - Data requesters (dREN|dWEN) beat instruction requesters.
  - Winner is the first requester at or after dptr (data) or iptr (instruction), wrapping modulo CPUS. The matching pointer becomes winner+1 mod CPUS.
  - Grant and word counter are latched. Transaction starts the next cycle; arbitration costs 1 cycle.
  - dWEN wins over dREN from the same core. Next state: dWEN→WRITE; dREN→SNOOP; iREN→IFETCH.
- IFETCH: ramREN=1, ramaddr=iaddr[g]. On ACCESS: iload[g]=ramload, iwait[g]=0 for that cycle, then →IDLE.
- WRITE (eviction/writeback):
  - Each word: ramWEN=1, ramaddr=daddr[g], ramstore=dstore[g].
  - On ACCESS: dwait[g]=0 and counter increments. Last word→IDLE.
- SNOOP (SNOOP_CYCLES cycles), for every core k≠g: ccwait[k]=1, ccsnoopaddr[k]=daddr[g], ccinv[k]=ccwrite[g].
- Snoop decision on the last SNOOP cycle:
  - Supplier s is the first k≠g with cctrans[k], searching g+1 upward with wrap.
  - No supplier→RAMRD.
  - ccwrite[g]=1→C2C_X.
  - ccwrite[g]=0→C2C_FLUSH.
- Snoop outputs stay driven (ccwait/ccsnoopaddr/ccinv) to all k≠g throughout the C2C states.
- C2C_X: dload[g]=dstore[s], dwait[g]=dwait[s]=0 every cycle. One word per cycle, no RAM traffic. Takes WORDS_PER_BLOCK cycles.
- C2C_FLUSH:
  - Same data path as C2C_X, plus ramWEN=1, ramaddr=daddr[s], ramstore=dstore[s].
  - dwait[g], dwait[s] drop only on ACCESS, where the counter advances.
- RAMRD: ramREN=1, ramaddr=daddr[g], dload[g]=ramload. dwait[g]=0 on ACCESS, where the counter advances.
- End of block: after the last word of any block state →IDLE. The counter resets to 0.
- Boundary conditions:
  - ramstate ERROR/BUSY/FREE: stall, outputs held.
  - Granted core drops its request mid-transaction: abort to IDLE next cycle, remaining words discarded, RAM enables low in the abort cycle.
  - New requests during a transaction are ignored until IDLE.
  - Async reset mid-operation: immediate return to reset values; a partial RAM write is permitted.

Decomposition:
- ramstate_t already lives in cpu_types_pkg.
- New coherence_pkg holds:
  - bus_state_t {IDLE, IFETCH, WRITE, SNOOP, C2C_X, C2C_FLUSH, RAMRD}
  - word-counter width $clog2(WORDS_PER_BLOCK+1)
- One sub-module, rr_arbiter #(N): request vector + pointer → one-hot grant, index, valid. Instantiated twice (data, instruction).

Test Plan:
- CPUS=4, WPB=2; dREN on cores 1 and 3, dptr=0 → core 1 granted, dptr=2. Core 3 granted in the following IDLE.
- Core 0 dREN, no cctrans, RAM ACCESS after 2 BUSY cycles → dload[0] gets both words, each with dwait[0]=0 for 1 cycle. Back in IDLE 2+2×3 cycles after grant.
- Core 2 dREN ccwrite=1, cctrans[1]=cctrans[3]=1 → supplier 3. ccinv[0,1,3]=1. Two C2C_X cycles, ramWEN=0 throughout.
- Core 0 dREN ccwrite=0, cctrans[1]=1, dstore[1]=0xDEADBEEF → dload[0] and ramstore both 0xDEADBEEF, ramaddr=daddr[1]. dwait[0], dwait[1] fall only on ACCESS.
- dWEN and iREN simultaneous on different cores → WRITE served first. IFETCH returns iload=ramload with iwait low 1 cycle.
- Core drops dREN after word 0 of RAMRD → IDLE next cycle, ramREN=0. Assert nRST low mid-C2C_FLUSH → all outputs at reset values the same cycle.
